minmax_stream: RTL and testbench

Streaming min/max tracker. Consumes a frame of up to N samples over a valid/ready input and produces one registered result per frame: maximum, minimum, sample count and, optionally, the frame position of each extreme. Supersedes the two-operand combinational min/max helper for datapaths that need extremes over a sequence, with signed or unsigned comparison and a backpressured result port.

---
 rtl/minmax_pkg.sv | 22 ++
 rtl/minmax_stream_if.sv | 45 ++++
 rtl/minmax_cmp.sv | 24 ++
 rtl/minmax_stream.sv | 140 ++++++++++++++
 tb/tb_minmax_stream.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/minmax_pkg.sv
// Shared types and width helpers for the minmax_stream block.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package minmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Width of a sample counter that must hold the values 1..n.
  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of a 0-based position within a frame of up to n samples.
  function automatic int iw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/minmax_stream_if.sv
// Sample-in / result-out bundle for minmax_stream; index fields exist only with MINMAX_IDX_EN.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on the sample side, out_valid/out_ready on the result side.
interface minmax_stream_if
  import minmax_pkg::*;
#(
  parameter int W = 20,
  parameter int N = 16
);
  localparam int CW = cw_of(N);
  localparam int IW = iw_of(N);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_max;
  logic [W-1:0]  out_min;
  logic [CW-1:0] out_count;
`ifdef MINMAX_IDX_EN
  logic [IW-1:0] out_max_idx;
  logic [IW-1:0] out_min_idx;
`endif

  // Producer of samples and consumer of results.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_min, out_count
`ifdef MINMAX_IDX_EN
    , input out_max_idx, out_min_idx
`endif
  );

  // The min/max tracker itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_min, out_count
`ifdef MINMAX_IDX_EN
    , output out_max_idx, out_min_idx
`endif
  );

endinterface

// File: rtl/minmax_cmp.sv
// Combinational magnitude comparator, signed or unsigned by parameter.
// Latency: combinational.
// Backpressure: not applicable.
module minmax_cmp #(
  parameter int W      = 20,
  parameter int SIGNED = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         a_gt_b,
  output logic         a_lt_b
);

  generate
    if (SIGNED != 0) begin : g_signed
      assign a_gt_b = $signed(a) > $signed(b);
      assign a_lt_b = $signed(a) < $signed(b);
    end else begin : g_unsigned
      assign a_gt_b = a > b;
      assign a_lt_b = a < b;
    end
  endgenerate

endmodule

// File: rtl/minmax_stream.sv
// Streaming frame min/max tracker; optional extreme positions under MINMAX_IDX_EN.
// Latency: result valid the cycle after the last sample is accepted; one sample/cycle within a frame.
// Backpressure: in_ready drops while a result is held; result held stable until out_ready.
module minmax_stream
  import minmax_pkg::*;
#(
  parameter int W      = 20,
  parameter int N      = 16,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  minmax_stream_if.slave  bus
);

  localparam int CW = cw_of(N);
  localparam int IW = iw_of(N);

  state_t        state;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [W-1:0]  max_r;
  logic [W-1:0]  min_r;
  logic [CW-1:0] cnt_r;
  logic          gt_max;
  logic          lt_min;
  logic          unused_cmp;
  logic          max_lt_unused;
  logic          min_gt_unused;
  logic          frame_full;

`ifdef MINMAX_IDX_EN
  logic [IW-1:0] max_idx_r;
  logic [IW-1:0] min_idx_r;
  logic [IW-1:0] pos;

  // In ACCUM the running count equals the position of the incoming sample.
  assign pos = cnt_r[IW-1:0];
  assign bus.out_max_idx = max_idx_r;
  assign bus.out_min_idx = min_idx_r;
`endif

  minmax_cmp #(.W(W), .SIGNED(SIGNED)) u_cmp_max (
    .a      (bus.in_data),
    .b      (max_r),
    .a_gt_b (gt_max),
    .a_lt_b (max_lt_unused)
  );

  minmax_cmp #(.W(W), .SIGNED(SIGNED)) u_cmp_min (
    .a      (bus.in_data),
    .b      (min_r),
    .a_gt_b (min_gt_unused),
    .a_lt_b (lt_min)
  );

  assign unused_cmp = max_lt_unused ^ min_gt_unused;

  // The incoming sample sits at position N-1, so it closes the frame regardless of in_last.
  assign frame_full = (cnt_r == CW'(N - 1));

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_max   = max_r;
  assign bus.out_min   = min_r;
  assign bus.out_count = cnt_r;

  // Frame FSM: seed on the first sample, fold in later ones, hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      max_r       <= '0;
      min_r       <= '0;
      cnt_r       <= '0;
`ifdef MINMAX_IDX_EN
      max_idx_r   <= '0;
      min_idx_r   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            max_r <= bus.in_data;
            min_r <= bus.in_data;
            cnt_r <= CW'(1);
`ifdef MINMAX_IDX_EN
            max_idx_r <= '0;
            min_idx_r <= '0;
`endif
            if (bus.in_last) begin
              state       <= HOLD;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            // Strict comparisons: on a tie the earlier position is kept.
            if (gt_max) begin
              max_r <= bus.in_data;
`ifdef MINMAX_IDX_EN
              max_idx_r <= pos;
`endif
            end
            if (lt_min) begin
              min_r <= bus.in_data;
`ifdef MINMAX_IDX_EN
              min_idx_r <= pos;
`endif
            end
            cnt_r <= cnt_r + CW'(1);
            if (bus.in_last || frame_full) begin
              state       <= HOLD;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_stream.sv
// Scoreboard bench: an unsigned and a signed W=8, N=4 tracker fed the same directed frames.
// Latency: expected results queued at stimulus time, compared when each result handshakes.
// Backpressure: exercises a long out_ready stall and a mid-frame reset.
module tb_minmax_stream;

  typedef struct {
    logic [7:0] mx;
    logic [7:0] mn;
    logic [2:0] cnt;
    logic [1:0] mxi;
    logic [1:0] mni;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  exp_t qu[$];
  exp_t qs[$];

  minmax_stream_if #(.W(8), .N(4)) bu ();
  minmax_stream_if #(.W(8), .N(4)) bs ();

  assign bu.in_valid  = in_valid;
  assign bu.in_data   = in_data;
  assign bu.in_last   = in_last;
  assign bu.out_ready = out_ready;
  assign bs.in_valid  = in_valid;
  assign bs.in_data   = in_data;
  assign bs.in_last   = in_last;
  assign bs.out_ready = out_ready;

  minmax_stream #(.W(8), .N(4), .SIGNED(0)) u_dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bu)
  );

  minmax_stream #(.W(8), .N(4), .SIGNED(1)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] mx, input logic [7:0] mn,
                              input logic [2:0] cnt, input logic [1:0] mxi,
                              input logic [1:0] mni);
    exp_t e;
    e.mx = mx; e.mn = mn; e.cnt = cnt; e.mxi = mxi; e.mni = mni;
    return e;
  endfunction

  // Present one sample and return #1 after the edge that accepts it.
  task automatic send(input logic [7:0] d, input logic l);
    int waited;
    waited = 0;
    while (!bu.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bu.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", bu.in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: compare each result on the cycle its handshake completes.
  always @(negedge clk) begin
    exp_t e;
    if (bu.out_valid && out_ready) begin
      if (qu.size() == 0) begin
        checks++; errors++;
        $display("FAIL u_unexpected: result max=%0h with empty queue", bu.out_max);
      end else begin
        e = qu.pop_front();
        chk("u_max", bu.out_max, e.mx);
        chk("u_min", bu.out_min, e.mn);
        chk("u_count", bu.out_count, e.cnt);
`ifdef MINMAX_IDX_EN
        chk("u_max_idx", bu.out_max_idx, e.mxi);
        chk("u_min_idx", bu.out_min_idx, e.mni);
`endif
      end
    end
    if (bs.out_valid && out_ready) begin
      if (qs.size() == 0) begin
        checks++; errors++;
        $display("FAIL s_unexpected: result max=%0h with empty queue", bs.out_max);
      end else begin
        e = qs.pop_front();
        chk("s_max", bs.out_max, e.mx);
        chk("s_min", bs.out_min, e.mn);
        chk("s_count", bs.out_count, e.cnt);
`ifdef MINMAX_IDX_EN
        chk("s_max_idx", bs.out_max_idx, e.mxi);
        chk("s_min_idx", bs.out_min_idx, e.mni);
`endif
      end
    end
  end

  initial begin
    int waited;

    // Reset state.
    #2;
    chk("rst_out_valid", bu.out_valid, 0);
    chk("rst_max", bu.out_max, 0);
    chk("rst_min", bu.out_min, 0);
    chk("rst_count", bu.out_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", bu.in_ready, 1);

    // Frame closed by N with no in_last; result stalled for 10 cycles.
    out_ready = 1'b0;
    qu.push_back(mk(8'h09, 8'h01, 3'd4, 2'd1, 2'd2));
    qs.push_back(mk(8'h09, 8'h01, 3'd4, 2'd1, 2'd2));
    send(8'h03, 1'b0);
    send(8'h09, 1'b0);
    send(8'h01, 1'b0);
    send(8'h07, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", bu.out_valid, 1);
      chk("hold_in_ready", bu.in_ready, 0);
      chk("hold_max", bu.out_max, 8'h09);
      chk("hold_min", bu.out_min, 8'h01);
      chk("hold_count", bu.out_count, 4);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_in_ready", bu.in_ready, 1);
    chk("post_hs_out_valid", bu.out_valid, 0);

    // Signed vs unsigned ordering around the sign boundary.
    qu.push_back(mk(8'h80, 8'h00, 3'd3, 2'd1, 2'd2));
    qs.push_back(mk(8'h7F, 8'h80, 3'd3, 2'd0, 2'd1));
    send(8'h7F, 1'b0);
    send(8'h80, 1'b0);
    send(8'h00, 1'b1);

    // Ties keep the earliest position.
    qu.push_back(mk(8'h05, 8'h02, 3'd4, 2'd0, 2'd2));
    qs.push_back(mk(8'h05, 8'h02, 3'd4, 2'd0, 2'd2));
    send(8'h05, 1'b0);
    send(8'h05, 1'b0);
    send(8'h02, 1'b0);
    send(8'h02, 1'b0);

    // Single-sample frame: result the cycle after acceptance.
    qu.push_back(mk(8'h3C, 8'h3C, 3'd1, 2'd0, 2'd0));
    qs.push_back(mk(8'h3C, 8'h3C, 3'd1, 2'd0, 2'd0));
    send(8'h3C, 1'b1);
    chk("single_latency", bu.out_valid, 1);

    // in_last without in_valid must not close the frame.
    qu.push_back(mk(8'h08, 8'h04, 3'd3, 2'd1, 2'd0));
    qs.push_back(mk(8'h08, 8'h04, 3'd3, 2'd1, 2'd0));
    send(8'h04, 1'b0);
    send(8'h08, 1'b0);
    in_last = 1'b1;
    @(posedge clk); #1;
    in_last = 1'b0;
    chk("gap_out_valid", bu.out_valid, 0);
    send(8'h06, 1'b1);

    // Mid-frame reset discards the partial frame.
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_u_valid", bu.out_valid, 0);
    chk("mid_rst_u_max", bu.out_max, 0);
    chk("mid_rst_u_min", bu.out_min, 0);
    chk("mid_rst_u_count", bu.out_count, 0);
    chk("mid_rst_s_valid", bs.out_valid, 0);
    chk("mid_rst_s_max", bs.out_max, 0);
    @(negedge clk);
    rst_n = 1'b1;
    qu.push_back(mk(8'hF0, 8'h10, 3'd3, 2'd1, 2'd0));
    qs.push_back(mk(8'h20, 8'hF0, 3'd3, 2'd2, 2'd1));
    send(8'h10, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h20, 1'b1);

    // Back-to-back frame at full rate.
    qu.push_back(mk(8'h04, 8'h01, 3'd4, 2'd3, 2'd0));
    qs.push_back(mk(8'h04, 8'h01, 3'd4, 2'd3, 2'd0));
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);

    // Drain the scoreboard.
    waited = 0;
    while ((qu.size() != 0 || qs.size() != 0) && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk); #1;
    if (qu.size() != 0 || qs.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d/%0d results still pending, required 0", qu.size(), qs.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
